// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets and elaboration helpers for the raster generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned display;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_cfg_t;

  // 640x480@60 (default) and 800x600@72 (1040x666 totals).
  localparam axis_cfg_t H640 = '{display: 640, front: 16, sync: 96, back: 48};
  localparam axis_cfg_t V480 = '{display: 480, front: 10, sync: 2, back: 33};
  localparam axis_cfg_t H800 = '{display: 800, front: 56, sync: 120, back: 64};
  localparam axis_cfg_t V600 = '{display: 600, front: 37, sync: 6, back: 23};

  localparam int unsigned ClkDivMax    = 16;
  localparam int unsigned PipeDelayMax = 7;

  function automatic int unsigned axis_total(input int unsigned display,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return display + front + sync + back;
  endfunction

  // Bits needed to hold total-1.
  function automatic int unsigned count_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster control/timing bundle between the timing generator and the pixel pipeline.
interface vga_timing_gen_if #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 10
);
  logic          enable;
  logic          pixEn;
  logic [HW-1:0] column;
  logic [VW-1:0] row;
  logic          displayActive;
  logic          hSync;
  logic          vSync;
  logic          lineStart;
  logic          frameStart;

  modport master (
    input  enable,
    output pixEn, column, row, displayActive, hSync, vSync, lineStart, frameStart
  );

  modport slave (
    output enable,
    input  pixEn, column, row, displayActive, hSync, vSync, lineStart, frameStart
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with visible-region and sync decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISPLAY = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48,
  parameter int unsigned W       = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance_i,
  output logic         wrap_o,
  output logic [W-1:0] count_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam int unsigned Total     = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam logic [W-1:0] Last      = W'(Total - 1);
  localparam logic [W-1:0] DispEnd   = W'(DISPLAY);
  localparam logic [W-1:0] SyncFirst = W'(DISPLAY + FRONT);
  localparam logic [W-1:0] SyncLast  = W'(DISPLAY + FRONT + SYNC - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    wrap_o  = (count_q == Last);
    count_d = count_q;
    if (advance_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
    count_o  = count_q;
    active_o = (count_q < DispEnd);
    sync_o   = (count_q >= SyncFirst) && (count_q <= SyncLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v axis counters,
// sync/blank decode and a pixel-tick delay line on the sync/active outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = H640.display,
  parameter int unsigned H_FRONT    = H640.front,
  parameter int unsigned H_SYNC     = H640.sync,
  parameter int unsigned H_BACK     = H640.back,
  parameter int unsigned V_DISPLAY  = V480.display,
  parameter int unsigned V_FRONT    = V480.front,
  parameter int unsigned V_SYNC     = V480.sync,
  parameter int unsigned V_BACK     = V480.back,
  parameter int unsigned CLK_DIV    = 2,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned PIPE_DELAY = 0,
  parameter int unsigned HW         = 10,
  parameter int unsigned VW         = 10
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);

  localparam int unsigned HTotal  = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal  = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam logic [3:0]  DivLast = 4'(CLK_DIV - 1);

  if (count_width(HTotal) > HW) begin : g_bad_hw
    $error("HW too narrow for H_TOTAL-1");
  end
  if (count_width(VTotal) > VW) begin : g_bad_vw
    $error("VW too narrow for V_TOTAL-1");
  end
  if (CLK_DIV < 1 || CLK_DIV > ClkDivMax) begin : g_bad_div
    $error("CLK_DIV out of range 1..16");
  end
  if (PIPE_DELAY > PipeDelayMax) begin : g_bad_delay
    $error("PIPE_DELAY out of range 0..7");
  end

  logic [3:0]    div_q, div_d;
  logic          started_q, started_d;
  logic          pix_en, h_adv, v_adv;
  logic          h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic [2:0]    dec, dly;

  always_comb begin
    pix_en = bus.enable && (div_q == DivLast);
    div_d  = div_q;
    if (bus.enable) begin
      div_d = pix_en ? '0 : div_q + 4'd1;
    end
    started_d = started_q | pix_en;
    // The first strobe only arms the raster so pixel (0,0) gets a full period.
    h_adv = pix_en & started_q;
    v_adv = h_adv & h_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      started_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      started_q <= started_d;
    end
  end

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(HW)
  ) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .advance_i(h_adv),
    .wrap_o   (h_wrap),
    .count_o  (h_count),
    .active_o (h_act),
    .sync_o   (h_sync)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(VW)
  ) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .advance_i(v_adv),
    .wrap_o   (v_wrap),
    .count_o  (v_count),
    .active_o (v_act),
    .sync_o   (v_sync)
  );

  assign dec = {started_q & h_act & v_act, started_q & h_sync, started_q & v_sync};

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign dly = dec;
  end else begin : g_delay
    logic [2:0] pipe_q [PIPE_DELAY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= '0;
      end else if (pix_en) begin
        pipe_q[0] <= dec;
        for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign dly = pipe_q[PIPE_DELAY-1];
  end

  // Line/frame markers flag the strobe on which the raster enters column 0 / pixel (0,0).
  always_comb begin
    bus.pixEn         = pix_en;
    bus.column        = h_count;
    bus.row           = v_count;
    bus.displayActive = dly[2];
    bus.hSync         = dly[1] ? H_POL : ~H_POL;
    bus.vSync         = dly[0] ? V_POL : ~V_POL;
    bus.lineStart     = pix_en & (~started_q | h_wrap);
    bus.frameStart    = pix_en & (~started_q | (h_wrap & v_wrap));
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: two small-raster configurations checked every
// clock against a tick-count reference model.
module tb_vga_timing_gen;

  // Config 0: default-style (CLK_DIV 2, no delay, active-low syncs).
  // Config 1: CLK_DIV 4, PIPE_DELAY 2, active-high syncs.
  localparam int HD [2] = '{20, 16};
  localparam int HF [2] = '{3, 2};
  localparam int HS [2] = '{4, 3};
  localparam int HB [2] = '{5, 4};
  localparam int VD [2] = '{10, 6};
  localparam int VF [2] = '{2, 1};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{3, 2};
  localparam int DV [2] = '{2, 4};
  localparam int PD [2] = '{0, 2};
  localparam int HP [2] = '{0, 1};
  localparam int VP [2] = '{0, 1};

  logic clk;
  logic rst;

  vga_timing_gen_if #(.HW(6), .VW(6)) if_a ();
  vga_timing_gen_if #(.HW(6), .VW(6)) if_b ();

  vga_timing_gen #(
    .H_DISPLAY(HD[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
    .V_DISPLAY(VD[0]), .V_FRONT(VF[0]), .V_SYNC(VS[0]), .V_BACK(VB[0]),
    .CLK_DIV(DV[0]), .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(PD[0]), .HW(6), .VW(6)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(if_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(HD[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
    .V_DISPLAY(VD[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
    .CLK_DIV(DV[1]), .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(PD[1]), .HW(6), .VW(6)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(if_b)
  );

  // {pixEn, column[5:0], row[5:0], displayActive, hSync, vSync, lineStart, frameStart}
  logic [17:0] obs [2];
  assign obs[0] = {if_a.pixEn, if_a.column, if_a.row, if_a.displayActive, if_a.hSync,
                   if_a.vSync, if_a.lineStart, if_a.frameStart};
  assign obs[1] = {if_b.pixEn, if_b.column, if_b.row, if_b.displayActive, if_b.hSync,
                   if_b.vSync, if_b.lineStart, if_b.frameStart};

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state: enabled cycles and pixel ticks since reset.
  int ecnt [2];
  int ticks [2];
  bit en [2];

  // Frame-level bookkeeping on config 0.
  bit seen_fs;
  int tick_run;
  int line_run;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int h_total(input int d);
    return HD[d] + HF[d] + HS[d] + HB[d];
  endfunction

  function automatic int v_total(input int d);
    return VD[d] + VF[d] + VS[d] + VB[d];
  endfunction

  // Raster decode after j pixel ticks; nothing is shown before the first tick.
  function automatic void decode(input int d, input int j, output bit act, output bit hs,
                                 output bit vs);
    int p, c, r;
    act = 1'b0;
    hs  = 1'b0;
    vs  = 1'b0;
    if (j >= 1) begin
      p   = (j - 1) % (h_total(d) * v_total(d));
      c   = p % h_total(d);
      r   = p / h_total(d);
      act = (c < HD[d]) && (r < VD[d]);
      hs  = (c >= HD[d] + HF[d]) && (c < HD[d] + HF[d] + HS[d]);
      vs  = (r >= VD[d] + VF[d]) && (r < VD[d] + VF[d] + VS[d]);
    end
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      string nm;
      bit    e_pix, e_act, e_hs, e_vs, e_ls, e_fs;
      int    e_col, e_row, p, per;
      nm    = (d == 0) ? "A" : "B";
      per   = h_total(d) * v_total(d);
      e_pix = en[d] && ((ecnt[d] % DV[d]) == DV[d] - 1);
      p     = (ticks[d] >= 1) ? (ticks[d] - 1) % per : 0;
      e_col = p % h_total(d);
      e_row = p / h_total(d);
      decode(d, ticks[d] - PD[d], e_act, e_hs, e_vs);
      e_ls  = e_pix && ((ticks[d] % h_total(d)) == 0);
      e_fs  = e_pix && ((ticks[d] % per) == 0);
      check_eq({nm, ".pixEn"},         int'(obs[d][17]),    int'(e_pix));
      check_eq({nm, ".column"},        int'(obs[d][16:11]), e_col);
      check_eq({nm, ".row"},           int'(obs[d][10:5]),  e_row);
      check_eq({nm, ".displayActive"}, int'(obs[d][4]),     int'(e_act));
      check_eq({nm, ".hSync"},         int'(obs[d][3]),     e_hs ? HP[d] : 1 - HP[d]);
      check_eq({nm, ".vSync"},         int'(obs[d][2]),     e_vs ? VP[d] : 1 - VP[d]);
      check_eq({nm, ".lineStart"},     int'(obs[d][1]),     int'(e_ls));
      check_eq({nm, ".frameStart"},    int'(obs[d][0]),     int'(e_fs));
    end
    if (obs[0][17]) tick_run++;
    if (obs[0][1]) line_run++;
    if (obs[0][0]) begin
      if (seen_fs) begin
        check_eq("A.ticks_per_frame", tick_run, h_total(0) * v_total(0));
        check_eq("A.lines_per_frame", line_run, v_total(0));
      end
      seen_fs  = 1'b1;
      tick_run = 0;
      line_run = 0;
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      ecnt[d]  = 0;
      ticks[d] = 0;
    end
    seen_fs  = 1'b0;
    tick_run = 0;
    line_run = 0;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic step(input bit r, input bit ea, input bit eb);
    @(negedge clk);
    rst         = r;
    if_a.enable = ea;
    if_b.enable = eb;
    en[0]       = ea;
    en[1]       = eb;
    if (r) reset_model();
    #1;
    compare_all();
    @(posedge clk);
    if (!r) begin
      for (int d = 0; d < 2; d++) begin
        if (en[d]) begin
          if ((ecnt[d] % DV[d]) == DV[d] - 1) ticks[d]++;
          ecnt[d]++;
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    if_a.enable = 1'b0;
    if_b.enable = 1'b0;
    reset_model();
    #2 rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    // Free-running for two full frames of each configuration.
    for (int i = 0; i < 2300; i++) step(1'b0, 1'b1, 1'b1);

    // Random enable gating, with one long 37-clock freeze.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        for (int g = 0; g < 37; g++) step(1'b0, 1'b0, 1'b0);
      end
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Occasional asynchronous resets mid-frame.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int g = 0; g < n; g++) step(1'b1, 1'b1, 1'b1);
      end
      step(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 controller. It derives a pixel-rate strobe from the system clock by an integer divider and runs horizontal and vertical counters. It produces sync, blanking, coordinate and frame/line markers with configurable porches, sync polarity and a programmable output delay. It sits between the clock/reset block and the pixel pipeline (framebuffer read, colour mux), and feeds the DAC/pin registers.

## Interface
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync widths, in pixels
- V_DISPLAY, 480: visible lines
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync widths, in lines
- CLK_DIV, 2: clk cycles per pixel, valid range 1..16
- H_POL, 0 / V_POL, 0: active level of hSync / vSync
- PIPE_DELAY, 0: pixel ticks of delay applied to hSync/vSync/displayActive, valid range 0..7
- HW, 10 / VW, 10: coordinate widths; H_TOTAL-1 must fit in HW and V_TOTAL-1 must fit in VW
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run; low freezes the raster
- pixEn  out  1  one-clk pixel strobe
- column  out  HW  current horizontal count
- row  out  VW  current vertical count
- displayActive  out  1  visible region, delayed by PIPE_DELAY
- hSync  out  1  horizontal sync, delayed by PIPE_DELAY
- vSync  out  1  vertical sync, delayed by PIPE_DELAY
- lineStart  out  1  high with pixEn when column==0
- frameStart  out  1  high with pixEn when column==0 and row==0

## Operation
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL is formed the same way.
- Divider divCnt runs 0..CLK_DIV-1 while enable=1. pixEn=1 when divCnt==CLK_DIV-1 and enable=1. With CLK_DIV=1, pixEn equals enable.
- On pixEn, hCount increments.
  - At H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - vCount wraps to 0 at V_TOTAL-1.
- Flag `started` clears on reset and sets on the first pixEn. The counters do not advance on that first pixEn, so pixel (0,0) occupies the first full pixel period.
- Decode, when started=1:
  - act = hCount<H_DISPLAY && vCount<V_DISPLAY
  - hs = hCount in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]
  - vs = vCount in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (whole lines)
- Decode, when started=0: act=0, hs=0, vs=0.
- Outputs: hSync = hs ? H_POL : ~H_POL; vSync = vs ? V_POL : ~V_POL.
- Delay line: act/hs/vs pass through a PIPE_DELAY-stage shift register that advances only on pixEn. Stages reset to inactive. row and column are never delayed.
- enable=0 holds divCnt, counters, the delay line and all outputs. pixEn, lineStart and frameStart stay 0. Re-asserting enable resumes at the same divider phase and raster position.

## Timing
- Reset values: pixEn 0, column 0, row 0, displayActive 0, hSync ~H_POL, vSync ~V_POL, lineStart 0, frameStart 0.
- First pixEn occurs at the CLK_DIV-th rising clk edge after rst deasserts, with enable high.
- Counters, and the lineStart/frameStart strobes derived from them, update on the clk edge where pixEn=1. They are stable for CLK_DIV cycles.
- With PIPE_DELAY=0, sync and active are a registered-counter decode aligned with column/row. With PIPE_DELAY=N, they describe the pixel N ticks earlier.
- Line wrap and frame wrap land on the same edge: at hCount=H_TOTAL-1 and vCount=V_TOTAL-1, both counters go to 0.
- Reset mid-frame returns everything to reset values within the same cycle (asynchronous). started clears, so the first output after release is pixel (0,0).

## Structure
- Package vga_timing_pkg holds:
  - the default 640x480@60 parameter set, plus an 800x600@72 set (1040x666 totals)
  - a function computing totals and required counter widths, used for elaboration-time assertions
- Sub-module vga_axis_counter (parameters DISPLAY, FRONT, SYNC, BACK, W). It has an advance input and a wrap output, plus count, active and sync outputs. It is instantiated once for the horizontal axis and once for the vertical axis, with the vertical instance advanced by the horizontal wrap.
- Divider, started flag and delay line live in the top module.

## Test plan
- Defaults, enable=1 for one frame: pixEn → 420000 strobes between consecutive frameStart pulses; lineStart → 525 per frame.
- Defaults, horizontal sync: hSync=0 for exactly 96 pixel ticks starting at column 656; displayActive falls at column 640.
- Defaults, vertical sync: vSync=0 while row is 490..491 (1600 ticks); displayActive=0 for every pixel of rows 480..524.
- CLK_DIV=4, PIPE_DELAY=2, H_POL=1: pixEn has a period of 4 clk; hSync rises 2 ticks after column reaches 656; displayActive falls when column=642.
- Deassert enable at column 100, row 200 for 37 clk: outputs frozen and pixEn=0 for the whole gap; the raster resumes at column 101 with the same divider phase.
- Assert rst at column 700, row 300: all outputs take reset values immediately; after release, the first frameStart coincides with the CLK_DIV-th edge.
